// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative cache controller: tag compare, true-LRU replacement,
// write-allocate on miss with evicted-tag report, and a one-set-per-cycle flush sweep.
module cache_way_lane #(
    parameter int TAG_W = 22,
    parameter int WAY_W = 2
) (
    input  logic             vld,
    input  logic [TAG_W-1:0] tag,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [WAY_W-1:0] age,
    input  logic [WAY_W-1:0] touch_age,
    input  logic             touch_sel,
    output logic             hit,
    output logic [WAY_W-1:0] age_nxt
);
    assign hit = vld && (tag == req_tag);

    always_comb begin
        age_nxt = age;
        if (touch_sel)
            age_nxt = '0;
        else if (age < touch_age)
            age_nxt = age + 1'b1;
    end
endmodule

module set_assoc_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAYS     = 4,
    parameter int SETS     = 256,
    parameter int OFFSET_W = 2,
    localparam int IDX_W   = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS),
    localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} state_t;
    typedef struct packed {
        logic              write;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
    } req_t;
    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

    function automatic age_vec_t age_init();
        for (int i = 0; i < WAYS; i++) age_init[i] = WAY_W'(i);
    endfunction
    localparam age_vec_t AGE_INIT = age_init();

    state_t                        state_q;
    req_t                          req_q;
    logic [IDX_W-1:0]              flush_cnt_q;
    logic                          req_ready_q, flush_done_q, resp_valid_q, resp_hit_q;
    logic                          resp_evict_q;
    logic [WAY_W-1:0]              resp_way_q;
    logic [DATA_W-1:0]             resp_rdata_q;
    logic [TAG_W-1:0]              resp_evict_tag_q;

    logic [WAYS-1:0]               valid_q [SETS];
    age_vec_t                      age_q   [SETS];
    logic [WAYS-1:0][TAG_W-1:0]    tag_q   [SETS];
    logic [WAYS-1:0][DATA_W-1:0]   data_q  [SETS];

    logic [WAYS-1:0]               set_valid, hit_vec, valid_set_d;
    age_vec_t                      set_age, age_set_d;
    logic [WAYS-1:0][TAG_W-1:0]    set_tag;
    logic [WAYS-1:0][DATA_W-1:0]   set_data;
    logic                          hit, do_touch, found_inv, unused_off;
    logic [WAY_W-1:0]              hit_way, victim, sel_way, touch_age;

    assign unused_off = ^req_addr[OFFSET_W-1:0];

    assign set_valid = valid_q[req_q.idx];
    assign set_age   = age_q[req_q.idx];
    assign set_tag   = tag_q[req_q.idx];
    assign set_data  = data_q[req_q.idx];

    for (genvar w = 0; w < WAYS; w++) begin : g_lane
        cache_way_lane #(.TAG_W(TAG_W), .WAY_W(WAY_W)) u_lane (
            .vld       (set_valid[w]),
            .tag       (set_tag[w]),
            .req_tag   (req_q.tag),
            .age       (set_age[w]),
            .touch_age (touch_age),
            .touch_sel (sel_way == WAY_W'(w)),
            .hit       (hit_vec[w]),
            .age_nxt   (age_set_d[w])
        );
    end

    // Victim: lowest-index invalid way first, otherwise the oldest way.
    always_comb begin
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int i = 0; i < WAYS; i++)
            if (hit_vec[i]) hit_way = WAY_W'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!set_valid[i]) begin
                victim    = WAY_W'(i);
                found_inv = 1'b1;
            end
        if (!found_inv)
            for (int i = 0; i < WAYS; i++)
                if (set_age[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
    end

    assign hit         = |hit_vec;
    assign sel_way     = hit ? hit_way : victim;
    assign touch_age   = set_age[sel_way];
    assign do_touch    = hit || req_q.write;
    assign valid_set_d = set_valid | (req_q.write ? (WAYS'(1) << sel_way) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= AGE_INIT;
            end
        end else if (state_q == FLUSH) begin
            valid_q[flush_cnt_q] <= '0;
            age_q[flush_cnt_q]   <= AGE_INIT;
        end else if (state_q == LOOKUP && do_touch) begin
            valid_q[req_q.idx] <= valid_set_d;
            age_q[req_q.idx]   <= age_set_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && req_q.write) begin
            tag_q[req_q.idx][sel_way]  <= req_q.tag;
            data_q[req_q.idx][sel_way] <= req_q.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            req_q            <= '0;
            flush_cnt_q      <= '0;
            req_ready_q      <= 1'b1;
            flush_done_q     <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            resp_way_q       <= '0;
            resp_rdata_q     <= '0;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                        req_ready_q <= 1'b0;
                    end else if (req_valid) begin
                        state_q     <= LOOKUP;
                        req_ready_q <= 1'b0;
                        req_q       <= '{write: req_write,
                                         tag:   req_addr[ADDR_W-1 -: TAG_W],
                                         idx:   req_addr[OFFSET_W +: IDX_W],
                                         wdata: req_wdata};
                    end
                end
                LOOKUP: begin
                    state_q          <= RESP;
                    resp_valid_q     <= 1'b1;
                    resp_hit_q       <= hit;
                    resp_way_q       <= do_touch ? sel_way : '0;
                    resp_rdata_q     <= (hit && !req_q.write) ? set_data[hit_way] : '0;
                    resp_evict_q     <= req_q.write && !hit && set_valid[sel_way];
                    resp_evict_tag_q <= (req_q.write && !hit && set_valid[sel_way])
                                        ? set_tag[sel_way] : '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == IDX_W'(SETS - 1)) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign flush_done     = flush_done_q;
    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_way       = resp_way_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_evict     = resp_evict_q;
    assign resp_evict_tag = resp_evict_tag_q;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Randomized bench for set_assoc_cache_ctrl against a recency-list cache model,
// plus directed cases with hand-computed expectations.
module tb_set_assoc_cache_ctrl;
    localparam int SETS  = 256;
    localparam int WAYS  = 4;
    localparam int TAG_W = 22;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, flush_req = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, flush_done, resp_valid, resp_hit, resp_evict;
    logic [1:0]  resp_way;
    logic [31:0] resp_rdata;
    logic [21:0] resp_evict_tag;

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush_req(flush_req), .flush_done(flush_done), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_way(resp_way), .resp_rdata(resp_rdata),
        .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          hit;
        int          way;
        bit          chk_way;
        logic [31:0] rdata;
        bit          evict;
        logic [21:0] etag;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        hit;
        logic [1:0]  way;
        logic [31:0] rdata;
        logic        evict;
        logic [21:0] etag;
    } obs_t;

    int total = 0, bad = 0;
    int pcyc = 0;
    int busy_lo = 0, busy_hi = -1, flush_due = -1;
    exp_t exq[$];

    bit          mval [SETS][WAYS];
    logic [21:0] mtag [SETS][WAYS];
    logic [31:0] mdat [SETS][WAYS];
    int          mru  [SETS][$];   // front = most recently used

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            mru[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                mval[s][w] = 1'b0;
                mru[s].push_back(w);
            end
        end
    endfunction

    function automatic void touch(input int s, input int w);
        for (int p = 0; p < mru[s].size(); p++)
            if (mru[s][p] == w) begin
                mru[s].delete(p);
                break;
            end
        mru[s].push_front(w);
    endfunction

    function automatic exp_t model_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int s, hw, v;
        logic [21:0] t;
        s = int'(a[9:2]);
        t = a[31:10];
        e.due = 0; e.hit = 0; e.way = 0; e.chk_way = 0; e.rdata = '0; e.evict = 0; e.etag = '0;
        hw = -1;
        for (int i = 0; i < WAYS; i++)
            if (mval[s][i] && mtag[s][i] == t) hw = i;
        if (hw >= 0) begin
            e.hit = 1; e.way = hw; e.chk_way = 1;
            if (wr) mdat[s][hw] = d;
            else    e.rdata = mdat[s][hw];
            touch(s, hw);
        end else if (wr) begin
            v = -1;
            for (int i = 0; i < WAYS; i++)
                if (!mval[s][i] && v < 0) v = i;
            if (v < 0) v = mru[s][WAYS-1];
            e.way = v; e.chk_way = 1;
            if (mval[s][v]) begin
                e.evict = 1;
                e.etag  = mtag[s][v];
            end
            mval[s][v] = 1'b1; mtag[s][v] = t; mdat[s][v] = d;
            touch(s, v);
        end
        return e;
    endfunction

    // Per-cycle comparison against the model's expected response/ready/flush timing.
    bit   ev;
    exp_t ce;
    always @(negedge clk) begin
        if (rst_n) begin
            ev = (exq.size() > 0) && (exq[0].due == pcyc);
            chk("resp_valid", 64'(resp_valid), 64'(ev));
            if (ev) begin
                ce = exq.pop_front();
                chk("resp_hit", 64'(resp_hit), 64'(ce.hit));
                if (ce.chk_way) chk("resp_way", 64'(resp_way), 64'(ce.way));
                chk("resp_rdata", 64'(resp_rdata), 64'(ce.rdata));
                chk("resp_evict", 64'(resp_evict), 64'(ce.evict));
                chk("resp_evict_tag", 64'(resp_evict_tag), 64'(ce.etag));
            end
            chk("req_ready", 64'(req_ready), 64'(!(pcyc >= busy_lo && pcyc <= busy_hi)));
            chk("flush_done", 64'(flush_done), 64'(pcyc == flush_due));
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        wait_ready();
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        e = model_access(wr, a, d);
        e.due = pcyc + 2;
        exq.push_back(e);
        busy_lo = pcyc + 1;
        busy_hi = pcyc + 2;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, output obs_t o);
        issue(wr, a, d);
        @(negedge clk);
        o.valid = resp_valid; o.hit = resp_hit; o.way = resp_way;
        o.rdata = resp_rdata; o.evict = resp_evict; o.etag = resp_evict_tag;
    endtask

    task automatic do_flush(input bit with_req, output int n);
        wait_ready();
        flush_req = 1'b1; req_valid = with_req; req_write = 1'b0; req_addr = 32'h2828;
        model_reset();
        busy_lo   = pcyc + 1;
        busy_hi   = pcyc + SETS;
        flush_due = pcyc + 1 + SETS;
        n = 0;
        @(negedge clk);
        flush_req = 1'b0; req_valid = 1'b0;
        while (!req_ready && n < SETS + 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_way", 64'(resp_way), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_resp_evict", 64'(resp_evict), 64'd0);
        chk("rst_evict_tag", 64'(resp_evict_tag), 64'd0);
    endtask

    // Assert reset 2 time units after a negedge, away from any active edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        exq.delete();
        busy_hi = -1;
        flush_due = -1;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        obs_t o;
        int   n;
        logic [31:0] a;
        model_reset();
        #7 chk_reset_outputs();
        @(negedge clk);
        #2 rst_n = 1'b1;

        do_req(1'b0, 32'h2828, 32'h0, o);
        chk("t1_valid", 64'(o.valid), 64'd1);
        chk("t1_hit", 64'(o.hit), 64'd0);
        chk("t1_rdata", 64'(o.rdata), 64'd0);

        do_req(1'b1, 32'h2828, 32'hA5A5A5A5, o);
        chk("t2_w_hit", 64'(o.hit), 64'd0);
        chk("t2_w_way", 64'(o.way), 64'd0);
        chk("t2_w_evict", 64'(o.evict), 64'd0);
        do_req(1'b0, 32'h2828, 32'h0, o);
        chk("t2_r_hit", 64'(o.hit), 64'd1);
        chk("t2_r_way", 64'(o.way), 64'd0);
        chk("t2_r_rdata", 64'(o.rdata), 64'hA5A5A5A5);

        for (int i = 0; i < 4; i++) begin
            a = 32'h2828 + 32'(i) * 32'h400;
            do_req(1'b1, a, 32'h100 + 32'(i), o);
            chk("t3_way", 64'(o.way), 64'(i));
        end
        do_req(1'b0, 32'h2828, 32'h0, o);
        chk("t3_r_hit", 64'(o.hit), 64'd1);
        do_req(1'b1, 32'h3828, 32'h77, o);
        chk("t3_evict_way", 64'(o.way), 64'd1);
        chk("t3_evict", 64'(o.evict), 64'd1);
        chk("t3_evict_tag", 64'(o.etag), 64'd11);

        do_req(1'b1, 32'h3028, 32'h1234, o);
        chk("t4_hit", 64'(o.hit), 64'd1);
        chk("t4_way", 64'(o.way), 64'd2);
        chk("t4_evict", 64'(o.evict), 64'd0);
        do_req(1'b0, 32'h3028, 32'h0, o);
        chk("t4_rdata", 64'(o.rdata), 64'h1234);

        do_flush(1'b1, n);
        chk("t5_busy_cycles", 64'(n), 64'(SETS));
        chk("t5_flush_done", 64'(flush_done), 64'd1);
        do_req(1'b0, 32'h2828, 32'h0, o);
        chk("t5_miss_after_flush", 64'(o.hit), 64'd0);

        do_req(1'b1, 32'h2828, 32'hBEEF, o);
        issue(1'b1, 32'h2828, 32'hDEAD);
        pulse_reset();
        do_req(1'b0, 32'h2828, 32'h0, o);
        chk("t6_miss_after_reset", 64'(o.hit), 64'd0);
        chk("t6_rdata", 64'(o.rdata), 64'd0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_flush(1'b0, n);
            end else if ($urandom_range(0, 199) == 0) begin
                issue(1'b1, 32'h2828, $urandom);
                pulse_reset();
            end else begin
                a = (32'($urandom_range(0, 6)) << 10) | (32'($urandom_range(0, 2)) << 2)
                    | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) a = $urandom;
                do_req(1'($urandom_range(0, 1)), a, $urandom, o);
            end
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
